// File: rtl/qspi_master.sv
// Quad-SPI transaction engine: one byte read/write per request to a flash or one of two QPI RAMs.
// Each nibble spends two cycles on the bus (clk low, then clk high), so the SPI clock runs at clock/2.
module qspi_master #(
   parameter int         DATA_BUS_WIDTH = 8,
   parameter int         ADDRESS_WIDTH  = 24,
   parameter int         DUMMY_CYCLES   = 6,
   parameter logic [7:0] CMD_READ       = 8'hEB,
   parameter logic [7:0] CMD_WRITE      = 8'h38
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      is_write,
   input  logic [1:0]                target,
   input  logic [ADDRESS_WIDTH-1:0]  addr,
   input  logic [DATA_BUS_WIDTH-1:0] wdata,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_BUS_WIDTH-1:0] rdata,
   input  logic [3:0]                spi_data_in,
   output logic [3:0]                spi_data_out,
   output logic [3:0]                spi_data_oe,
   output logic                      spi_clk_out,
   output logic                      spi_flash_select,
   output logic                      spi_ram_a_select,
   output logic                      spi_ram_b_select
);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_DESELECT
   } state_t;

   state_t      state_r;
   state_t      adv_state_s;
   logic [4:0]  cnt_r;
   logic [4:0]  adv_cnt_s;
   logic        phase_r;
   logic        is_write_r;
   logic [23:0] addr_r;
   logic [7:0]  wdata_r;
   logic [7:0]  rbuf_r;
   logic        reject_s;

   function automatic logic [4:0] last_cnt(input state_t st);
      case (st)
         S_CMD, S_RDATA, S_WDATA: last_cnt = 5'd1;
         S_ADDR:                  last_cnt = 5'd5;
         S_DUMMY:                 last_cnt = 5'(DUMMY_CYCLES - 1);
         default:                 last_cnt = 5'd0;
      endcase
   endfunction

   // Outgoing nibble for a given phase/index; uses the latched request fields.
   function automatic logic [3:0] nib_of(input state_t st, input logic [4:0] idx);
      logic [7:0] cmd;
      cmd = is_write_r ? CMD_WRITE : CMD_READ;
      case (st)
         S_CMD:   nib_of = (idx == 5'd0) ? cmd[7:4] : cmd[3:0];
         S_WDATA: nib_of = (idx == 5'd0) ? wdata_r[7:4] : wdata_r[3:0];
         S_ADDR: begin
            case (idx)
               5'd0:    nib_of = addr_r[23:20];
               5'd1:    nib_of = addr_r[19:16];
               5'd2:    nib_of = addr_r[15:12];
               5'd3:    nib_of = addr_r[11:8];
               5'd4:    nib_of = addr_r[7:4];
               5'd5:    nib_of = addr_r[3:0];
               default: nib_of = 4'h0;
            endcase
         end
         default: nib_of = 4'h0;
      endcase
   endfunction

   function automatic logic drives_bus(input state_t st);
      drives_bus = (st == S_CMD) || (st == S_ADDR) || (st == S_WDATA);
   endfunction

   assign reject_s = (target == 2'd3) || (is_write && (target == 2'd0));

   // Phase/index that follows the nibble currently finishing.
   always_comb begin
      adv_state_s = state_r;
      adv_cnt_s   = cnt_r + 5'd1;
      if (cnt_r == last_cnt(state_r)) begin
         adv_cnt_s = 5'd0;
         case (state_r)
            S_CMD:            adv_state_s = S_ADDR;
            S_ADDR:           adv_state_s = is_write_r ? S_WDATA :
                                            ((DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY);
            S_DUMMY:          adv_state_s = S_RDATA;
            S_RDATA, S_WDATA: adv_state_s = S_DESELECT;
            default:          adv_state_s = state_r;
         endcase
      end else begin
         adv_cnt_s = cnt_r + 5'd1;
      end
   end

   // Transaction FSM with all pin and handshake outputs registered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r          <= S_IDLE;
         cnt_r            <= 5'd0;
         phase_r          <= 1'b0;
         is_write_r       <= 1'b0;
         addr_r           <= 24'h000000;
         wdata_r          <= 8'h00;
         rbuf_r           <= 8'h00;
         busy             <= 1'b0;
         done             <= 1'b0;
         rdata            <= '0;
         spi_data_out     <= 4'h0;
         spi_data_oe      <= 4'h0;
         spi_clk_out      <= 1'b0;
         spi_flash_select <= 1'b1;
         spi_ram_a_select <= 1'b1;
         spi_ram_b_select <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               spi_clk_out <= 1'b0;
               spi_data_oe <= 4'h0;
               if (start) begin
                  is_write_r <= is_write;
                  addr_r     <= 24'(addr);
                  wdata_r    <= wdata;
                  if (reject_s) begin
                     done <= 1'b1;
                  end else begin
                     state_r          <= S_SELECT;
                     busy             <= 1'b1;
                     spi_flash_select <= (target != 2'd0);
                     spi_ram_a_select <= (target != 2'd1);
                     spi_ram_b_select <= (target != 2'd2);
                  end
               end
            end
            S_SELECT: begin
               state_r      <= S_CMD;
               cnt_r        <= 5'd0;
               phase_r      <= 1'b0;
               spi_clk_out  <= 1'b0;
               spi_data_out <= nib_of(S_CMD, 5'd0);
               spi_data_oe  <= 4'hF;
            end
            S_DESELECT: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
               if (!is_write_r) rdata <= rbuf_r;
            end
            default: begin
               if (!phase_r) begin
                  phase_r     <= 1'b1;
                  spi_clk_out <= 1'b1;
               end else begin
                  phase_r      <= 1'b0;
                  spi_clk_out  <= 1'b0;
                  if (state_r == S_RDATA) rbuf_r <= {rbuf_r[3:0], spi_data_in};
                  state_r      <= adv_state_s;
                  cnt_r        <= adv_cnt_s;
                  spi_data_out <= nib_of(adv_state_s, adv_cnt_s);
                  spi_data_oe  <= drives_bus(adv_state_s) ? 4'hF : 4'h0;
                  if (adv_state_s == S_DESELECT) begin
                     spi_flash_select <= 1'b1;
                     spi_ram_a_select <= 1'b1;
                     spi_ram_b_select <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_master.sv
// Scoreboard bench for qspi_master: expected transactions and IO nibbles are queued at stimulus time
// and consumed by a cycle monitor that also plays the role of the SPI devices.
module tb_qspi_master;

   localparam int DUMMY = 6;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        is_write;
   logic [1:0]  target;
   logic [23:0] addr;
   logic [7:0]  wdata;
   logic        busy;
   logic        done;
   logic [7:0]  rdata;
   logic [3:0]  spi_data_in;
   logic [3:0]  spi_data_out;
   logic [3:0]  spi_data_oe;
   logic        spi_clk_out;
   logic        spi_flash_select;
   logic        spi_ram_a_select;
   logic        spi_ram_b_select;

   qspi_master dut (
      .clock(clock), .reset(reset), .start(start), .is_write(is_write),
      .target(target), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .rdata(rdata), .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
      .spi_data_oe(spi_data_oe), .spi_clk_out(spi_clk_out),
      .spi_flash_select(spi_flash_select), .spi_ram_a_select(spi_ram_a_select),
      .spi_ram_b_select(spi_ram_b_select)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         done_cyc;
      logic [7:0] rd;
      logic [2:0] sel;
      int         nclk;
      bit         w;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] exp_io[$];
   logic [7:0] dev_q[$];
   logic [7:0] model_rd = 8'h00;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         ignore = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input int t0, input bit w, input logic [1:0] tg,
                           input logic [23:0] a, input logic [7:0] wd, input logic [7:0] dev);
      exp_t       e;
      logic [7:0] cmd;
      e.w = w;
      if (tg == 2'd3 || (w && tg == 2'd0)) begin
         e.done_cyc = t0; e.rd = model_rd; e.sel = 3'b111; e.nclk = 0;
      end else begin
         cmd = w ? 8'h38 : 8'hEB;
         exp_io.push_back(cmd[7:4]);
         exp_io.push_back(cmd[3:0]);
         for (int k = 5; k >= 0; k--) exp_io.push_back(a[4*k +: 4]);
         if (w) begin
            exp_io.push_back(wd[7:4]);
            exp_io.push_back(wd[3:0]);
            e.nclk = 10;
         end else begin
            model_rd = dev;
            dev_q.push_back(dev);
            e.nclk = 10 + DUMMY;
         end
         e.done_cyc = t0 + 2 + 2 * e.nclk;
         e.rd = model_rd;
         e.sel = (tg == 2'd0) ? 3'b110 : (tg == 2'd1) ? 3'b101 : 3'b011;
      end
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
      check("drain", sb.size(), 0);
      sb.delete();
   endtask

   task automatic issue(input bit w, input logic [1:0] tg, input logic [23:0] a,
                        input logic [7:0] wd, input logic [7:0] dev);
      @(negedge clock);
      is_write = w; target = tg; addr = a; wdata = wd; start = 1'b1;
      push_exp(cyc + 1, w, tg, a, wd, dev);
      @(negedge clock);
      start = 1'b0;
      wait_idle();
   endtask

   // Cycle monitor and device model, sampled 1 time unit after each rising edge.
   initial begin
      logic [2:0] sel;
      logic [7:0] dev_cur = 8'h00;
      int         nib = 0;
      int         nclk = 0;
      logic       prev_clk = 1'b0;
      exp_t       e;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         sel = {spi_ram_b_select, spi_ram_a_select, spi_flash_select};
         if (ignore) begin
            nib = 0; nclk = 0; prev_clk = 1'b0;
         end else begin
            if (sel == 3'b111) begin
               nib = 0;
               check("idle_pins", {spi_clk_out, spi_data_oe}, 5'b0);
            end else if (sb.size() == 0) begin
               check("sel_unexp", sel, 3'b111);
            end else begin
               check("sel", sel, sb[0].sel);
            end
            if (spi_clk_out) begin
               check("clk_period", prev_clk, 1'b0);
               if (sb.size() != 0 && !sb[0].w && nib >= 8) begin
                  check("oe_rd", spi_data_oe, 4'h0);
               end else begin
                  check("oe_drv", spi_data_oe, 4'hF);
                  if (exp_io.size() == 0) check("io_extra", spi_data_out, 4'h0 ^ spi_data_out ^ 4'hF);
                  else check("io", spi_data_out, exp_io.pop_front());
               end
               if (nib == 8 + DUMMY) begin
                  dev_cur = (dev_q.size() != 0) ? dev_q.pop_front() : 8'h00;
                  spi_data_in = dev_cur[7:4];
               end else if (nib == 9 + DUMMY) begin
                  spi_data_in = dev_cur[3:0];
               end else begin
                  spi_data_in = 4'h6;
               end
               nib++;
               nclk++;
            end
            prev_clk = spi_clk_out;
            if (sb.size() != 0 && sb[0].nclk == 0) check("rej_busy", busy, 1'b0);
            if (done) begin
               if (sb.size() == 0) begin
                  check("done_unexp", done, 1'b0);
               end else begin
                  e = sb.pop_front();
                  check("latency", cyc, e.done_cyc);
                  check("rdata", rdata, e.rd);
                  check("busy_done", busy, 1'b0);
                  check("nclk", nclk, e.nclk);
               end
               nclk = 0;
            end
         end
      end
   end

   initial begin
      int t0;
      reset = 1'b0; start = 1'b0; is_write = 1'b0; target = 2'd0;
      addr = 24'h0; wdata = 8'h0; spi_data_in = 4'h0;
      repeat (2) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_pins", {spi_clk_out, spi_data_out, spi_data_oe}, 9'h000);
      check("rst_sel", {spi_ram_b_select, spi_ram_a_select, spi_flash_select}, 3'b111);
      reset = 1'b1;
      ignore = 1'b0;

      // Abort a RAM A read during address nibble 3; it must never complete.
      @(negedge clock);
      ignore = 1'b1;
      is_write = 1'b0; target = 2'd1; addr = 24'hABCDEF; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("abort_busy_pre", busy, 1'b1);
      repeat (11) @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort_sel", {spi_ram_b_select, spi_ram_a_select, spi_flash_select}, 3'b111);
      check("abort_pins", {spi_clk_out, spi_data_oe}, 5'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      ignore = 1'b0;

      issue(1'b0, 2'd0, 24'h012345, 8'h00, 8'hA5);
      issue(1'b1, 2'd2, 24'h00FF10, 8'h3C, 8'h00);
      issue(1'b1, 2'd0, 24'h000100, 8'h77, 8'h00);
      issue(1'b0, 2'd3, 24'h000200, 8'h00, 8'h00);
      issue(1'b0, 2'd1, 24'h123456, 8'h00, 8'h5A);
      issue(1'b1, 2'd1, 24'hFEDCBA, 8'hC3, 8'h00);

      // Start held high: second read accepted in the first done cycle, starts while busy ignored.
      @(negedge clock);
      is_write = 1'b0; target = 2'd1; addr = 24'h000040; start = 1'b1;
      t0 = cyc + 1;
      push_exp(t0, 1'b0, 2'd1, 24'h000040, 8'h00, 8'h11);
      push_exp(t0 + 35, 1'b0, 2'd1, 24'h000040, 8'h00, 8'h22);
      repeat (40) @(negedge clock);
      start = 1'b0;
      wait_idle();

      repeat (3) @(negedge clock);
      check("final_rdata", rdata, 8'h22);
      check("io_left", exp_io.size(), 0);
      check("dev_left", dev_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
